// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed non-restoring divider, Z layout {remainder, quotient}
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               in_reset,
    input  logic               in_start,
    input  logic [WIDTH-1:0]   in_dividend,
    input  logic [WIDTH-1:0]   in_divisor,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_busy,
    output logic               out_done,
    output logic               out_div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state;
    logic [WIDTH:0]  rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]   count;
    logic            neg_q;
    logic            neg_r;

    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   stepped;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic             dvs_zero;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign dvs_ext  = {1'b0, dvs};
    assign shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign stepped  = rem[WIDTH] ? shifted + dvs_ext : shifted - dvs_ext;
    assign dvs_zero = (dvs == '0);

    // Final remainder lies in [0, |divisor|), so the low WIDTH bits suffice after restoring.
    assign rem_mag = rem[WIDTH] ? rem[WIDTH-1:0] + dvs : rem[WIDTH-1:0];
    assign r_final = neg_r ? -rem_mag : rem_mag;
    // With a zero divisor every step subtracts nothing, leaving |dividend| in the remainder.
    assign q_final = dvs_zero ? '1 : (neg_q ? -quo : quo);

    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            state           <= IDLE;
            rem             <= '0;
            quo             <= '0;
            dvs             <= '0;
            count           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            out_result      <= '0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_div_by_zero <= 1'b0;
        end else if (in_start) begin
            neg_q    <= in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
            neg_r    <= in_dividend[WIDTH-1];
            quo      <= magnitude(in_dividend);
            dvs      <= magnitude(in_divisor);
            rem      <= '0;
            count    <= '0;
            out_busy <= 1'b1;
            out_done <= 1'b0;
            state    <= RUN;
        end else begin
            case (state)
                RUN: begin
                    rem   <= stepped;
                    quo   <= {quo[WIDTH-2:0], ~stepped[WIDTH]};
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_result      <= {r_final, q_final};
                    out_div_by_zero <= dvs_zero;
                    out_busy        <= 1'b0;
                    out_done        <= 1'b1;
                    state           <= DONE;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        in_reset;
    logic        in_start;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic [63:0] out_result;
    logic        out_busy;
    logic        out_done;
    logic        out_div_by_zero;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] last_result;

    seq_divider #(.WIDTH(32)) dut (
        .clk             (clk),
        .in_reset        (in_reset),
        .in_start        (in_start),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .out_result      (out_result),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_div_by_zero (out_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // hold = number of consecutive edges with in_start high; the last one is E0
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input logic [63:0] exp_res, input logic exp_dbz);
        logic run_ok;
        @(negedge clk);
        in_dividend = a;
        in_divisor  = b;
        in_start    = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        in_start    = 1'b0;
        in_dividend = 32'hDEAD_BEEF;
        in_divisor  = 32'h0000_0003;
        run_ok = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            if (!(out_busy === 1'b1 && out_done === 1'b0 && out_result === last_result))
                run_ok = 1'b0;
        end
        chk({tag, " run"}, {63'd0, run_ok}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, " done/busy"}, {62'd0, out_done, out_busy}, 64'd2);
        chk({tag, " result"}, out_result, exp_res);
        chk({tag, " dbz"}, {63'd0, out_div_by_zero}, {63'd0, exp_dbz});
        last_result = exp_res;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_dividend = a;
        in_divisor  = b;
        in_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_reset    = 1'b1;
        in_start    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        last_result = '0;
        #12;
        chk("reset outputs", {out_result[60:0], out_busy, out_done, out_div_by_zero}, 64'd0);
        @(negedge clk);
        in_reset = 1'b0;

        run_div("100/7",   32'd100,        32'd7,          1, 64'h00000002_0000000E, 1'b0);
        run_div("-100/7",  -32'sd100,      32'd7,          1, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
        run_div("100/-7",  32'd100,        -32'sd7,        1, 64'h00000002_FFFFFFF2, 1'b0);
        run_div("-100/-7", -32'sd100,      -32'sd7,        1, 64'hFFFFFFFE_0000000E, 1'b0);
        run_div("5/0",     32'd5,          32'd0,          1, 64'h00000005_FFFFFFFF, 1'b1);
        run_div("6/3",     32'd6,          32'd3,          2, 64'h00000000_00000002, 1'b0);
        run_div("-5/0",    -32'sd5,        32'd0,          1, 64'hFFFFFFFB_FFFFFFFF, 1'b1);
        run_div("min/-1",  32'h8000_0000,  32'hFFFF_FFFF,  1, 64'h00000000_80000000, 1'b0);
        run_div("max/1",   32'h7FFF_FFFF,  32'd1,          1, 64'h00000000_7FFFFFFF, 1'b0);
        run_div("0/5",     32'd0,          32'd5,          1, 64'h00000000_00000000, 1'b0);
        run_div("min/7",   32'h8000_0000,  32'd7,          1, 64'hFFFFFFFE_EDB6DB6E, 1'b0);

        run_div("100/7b",  32'd100,        32'd7,          1, 64'h00000002_0000000E, 1'b0);
        launch(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        in_reset = 1'b1;
        #1;
        chk("async reset", {out_result[60:0], out_busy, out_done, out_div_by_zero}, 64'd0);
        @(negedge clk);
        in_reset    = 1'b0;
        last_result = '0;
        run_div("9/3 after reset", 32'd9, 32'd3, 1, 64'h00000000_00000003, 1'b0);

        launch(32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        run_div("9/4 restart", 32'd9, 32'd4, 1, 64'h00000001_00000002, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle signed 32-bit divider for the ALU's DIV operation (ALU opcode 4'b1001), fed by the control unit's div_reset pulse and its Y register and bus operands.
- Produces a 64-bit result in Z layout: Z-hi holds the remainder, Z-lo holds the quotient.
- The control unit then moves Z-lo to LO (div5) and Z-hi to HI (div6).
- Completes within the 34-cycle window the control unit holds in div4.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; result width is 2*WIDTH.

Ports:
clk  input  1  clock, rising edge
in_reset  input  1  asynchronous active-high reset
in_start  input  1  synchronous load/start pulse (control unit out_div_reset)
in_dividend  input  WIDTH  dividend, two's complement (Y register)
in_divisor  input  WIDTH  divisor, two's complement (bus, Rb)
out_result  output  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient
out_busy  output  1  high while a division is in progress
out_done  output  1  high from completion until the next start or reset
out_div_by_zero  output  1  latched: last completed division had divisor 0

Behaviour:
- Reset is clk, in_reset, asynchronous, active-high. On reset:
  - state goes to IDLE.
  - out_result=0, out_busy=0, out_done=0, out_div_by_zero=0.
  - Iteration counter and internal registers are cleared.
- States: IDLE, RUN, FIX, DONE.
- Edge E0, in_start=1 sampled in any state:
  - Capture operand signs, |dividend| and |divisor| (unsigned WIDTH-bit magnitudes).
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - out_busy=1, out_done=0; go to RUN.
  - in_start has priority over all other transitions, so a start while busy aborts and restarts.
- RUN, edges E1..E32: one non-restoring step per edge.
  - Shift the remainder:quotient pair left by 1.
  - Add or subtract the divisor magnitude according to the remainder sign; set quotient bit = ~sign.
  - Counter increments; after WIDTH steps go to FIX.
- FIX, edge E33:
  - If the partial remainder is negative, add the divisor magnitude back.
  - Apply signs: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Write out_result and out_div_by_zero; out_busy=0, out_done=1; go to DONE.
- Latency: the result is valid and out_done=1 after exactly WIDTH+1 = 33 edges following E0.
- DONE holds out_result and out_done until the next in_start or reset.
- out_result holds its previous value during RUN/FIX and is only updated at FIX.
- Operands are sampled only at E0; later changes on in_dividend/in_divisor have no effect.
- Divisor 0:
  - Runs the full 33 cycles (fixed latency).
  - Quotient = all ones, remainder = dividend unchanged, out_div_by_zero=1.
- Overflow (-2^(W-1) / -1): quotient = 0x80000000, remainder = 0, no flag.
- Magnitude of -2^(W-1) is treated as unsigned 2^(W-1); no truncation error.
- Reset mid-operation: immediate return to IDLE with all outputs zero; no partial result is visible.
- in_start held high for multiple cycles: each sampled edge restarts; computation begins on the first edge where in_start=0 follows.

Test Plan:
1. Start with 100 / 7 -> exactly 33 edges later out_done=1, out_busy=0, out_result=0x00000002_0000000E; busy high on edges E1..E32.
2. Signed operands: -100/7 -> Q=0xFFFFFFF2, R=0xFFFFFFFE; 100/-7 -> Q=0xFFFFFFF2, R=0x00000002; -100/-7 -> Q=0x0000000E, R=0xFFFFFFFE.
3. Divide by zero, 5/0 -> out_result=0x00000005_FFFFFFFF, out_div_by_zero=1 after 33 edges; a following 6/3 clears the flag, result 0x00000000_00000002.
4. Edge values: 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0; 0x7FFFFFFF / 1 -> Q=0x7FFFFFFF, R=0; 0/5 -> 0.
5. Assert in_reset asynchronously at iteration 10 of 1000/3 -> all outputs 0 immediately; after release, start 9/3 -> Q=3, R=0 after 33 edges.
6. Re-assert in_start at iteration 20 of 1000/3 with 9/4 -> out_done stays 0 until 33 edges after the second start; result Q=2, R=1; no 1000/3 result ever appears.
